permutation_iterator: RTL and testbench
=======================================

Name: permutation_iterator

Overview:
- Sequential driver for the Ascon permutation; sits directly upstream of constant_addition and owns the 320-bit state register.
- Its registered state and round index feed constant_addition, which chains combinationally into substitution_layer and diffusion_layer.
- Result is registered back each clock: one permutation round per cycle.
- Provides a start/done handshake so the mode FSM can request p^a (12 rounds) or p^b (6 rounds).

Parameters:
- ROUND_LAST, 11, index of final round; every permutation ends on this round.
- ROUNDS_B_START, 6, first round index for p^b (6-round) mode; p^a starts at 0.

Ports:
- clock_i  in  1  system clock; all state changes on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  request; sampled only in IDLE.
- rounds_sel_i  in  1  0 = p^a (rounds 0..11), 1 = p^b (rounds 6..11); sampled with start_i.
- state_i  in  type_state  5x64 permutation input; sampled with start_i.
- state_o  out  type_state  state register contents; holds final result after done_o.
- round_o  out  4  round index currently driven to constant_addition.round_i.
- busy_o  out  1  high in RUN and DONE.
- done_o  out  1  one-cycle pulse; state_o is valid while done_o is high.

Behaviour:
- Reset, while reset_i=1 at an edge:
  - FSM goes to IDLE.
  - state register becomes all zero; round register becomes 0.
  - Outputs: state_o=0, round_o=0, busy_o=0, done_o=0.
  - Reset applies from any state, including mid-permutation; the in-flight computation is discarded and no done_o is produced.
- FSM states: IDLE, RUN, DONE. Moore outputs.
- IDLE:
  - start_i=1 at an edge: load state_i into the state register; round register <= (rounds_sel_i ? ROUNDS_B_START : 0); go to RUN.
  - start_i=0: hold state register and round register unchanged, so the last result stays visible.
- RUN:
  - Each edge: state register <= diffusion(substitution(constant_addition(state register, round register))).
  - If round register = ROUND_LAST: go to DONE and leave the round register unchanged.
  - Otherwise: round register <= round register + 1.
- DONE: done_o=1 for exactly one cycle; next edge goes to IDLE. The state register is not modified.
- Round constant (applied inside constant_addition, listed here for verification): state[2][7:0] ^= {~r[3:0], r[3:0]}. Examples: r=0 gives 0xF0, r=6 gives 0x96, r=11 gives 0x4B.
- Latency (start sampled at edge k):
  - RUN spans edges k+1 .. k+N, with N=12 for p^a and N=6 for p^b.
  - done_o is high between edge k+N and edge k+N+1.
  - Total: start to done = N cycles; start to next accepted start = N+2 cycles.
- start_i while busy_o=1 (RUN or DONE): ignored; no queuing, no restart.
- start_i high in the IDLE cycle right after DONE: accepted normally, giving back-to-back operation.
- round_o: equals the round register in every state; the round register never exceeds ROUND_LAST.
- state_i and rounds_sel_i are ignored outside the start edge; they may change freely during RUN.

Optional Feature:
- Macro: PERM_UNROLL2_EN.
- Defined:
  - Two rounds are instantiated back to back; each RUN edge applies rounds r and r+1.
  - Round register increments by 2; the exit test is (round register + 1 = ROUND_LAST).
  - N becomes 6 cycles for p^a and 3 cycles for p^b.
  - round_o shows the first round of the pair.
  - Final state_o is bit-identical to the non-unrolled build.
- Not defined: one round per cycle, exactly as described above.

Test Plan:
- p^a: state_i = {80400c0600000000, 8a55114d1cb6a9a2, be263d4d7aecaaff, 4ed0ec0b98c529b7, c8cddf37bcd0284a}, rounds_sel_i=0, pulse start_i -> round_o steps 0,1,..,11 on consecutive cycles; done_o is high exactly 12 cycles after the start edge; state_o equals the golden software Ascon p^a of the same input.
- p^b: same input, rounds_sel_i=1 -> round_o steps 6..11; done_o 6 cycles after start; state_o equals golden p^b. On the first RUN cycle, the constant_addition output word 2 low byte equals 0xff^0x96 = 0x69.
- Start ignored while busy: assert start_i continuously during RUN with a different state_i -> exactly one done_o; result matches the first request; a new start is accepted in the IDLE cycle after DONE.
- Reset mid-operation: reset_i=1 at round_o=5 -> next cycle state_o=0, round_o=0, busy_o=0; no done_o pulse for that run.
- Hold after done: no start for 20 cycles after done_o -> state_o stable, round_o=11, busy_o=0.
- With PERM_UNROLL2_EN: repeat the p^a and p^b vectors -> done_o at 6 and 3 cycles; round_o sequences 0,2,..,10 and 6,8,10; state_o identical to the non-unrolled results.

Source files
------------

// File: rtl/permutation_iterator.sv
// Ascon permutation driver: owns the 320-bit state and applies one round per clock
// (two per clock when PERM_UNROLL2_EN is defined), with a start/done handshake.
module permutation_iterator #(
    parameter int ROUND_LAST     = 11,
    parameter int ROUNDS_B_START = 6
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         rounds_sel_i,
    input  logic [319:0] state_i,
    output logic [319:0] state_o,
    output logic [3:0]   round_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

`ifdef PERM_UNROLL2_EN
    localparam logic [3:0] ROUND_STEP = 4'd2;
`else
    localparam logic [3:0] ROUND_STEP = 4'd1;
`endif

    fsm_t           fsm_reg;
    logic [319:0]   state_reg;
    logic [3:0]     round_reg;
    logic           busy_reg;
    logic           done_reg;
    logic [319:0]   state_next;
    logic           last_round;

    function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Constant addition, bitsliced 5-bit S-box and linear diffusion for round r.
    // Word x0 sits in the most significant 64 bits of the flat state.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        x2[7:0] = x2[7:0] ^ {~r, r};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

`ifdef PERM_UNROLL2_EN
    assign state_next = ascon_round(ascon_round(state_reg, round_reg), round_reg + 4'd1);
    assign last_round = ((round_reg + 4'd1) == 4'(ROUND_LAST));
`else
    assign state_next = ascon_round(state_reg, round_reg);
    assign last_round = (round_reg == 4'(ROUND_LAST));
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_reg   <= IDLE;
            state_reg <= '0;
            round_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (fsm_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start_i) begin
                        state_reg <= state_i;
                        round_reg <= rounds_sel_i ? 4'(ROUNDS_B_START) : 4'd0;
                        busy_reg  <= 1'b1;
                        fsm_reg   <= RUN;
                    end
                end
                RUN: begin
                    state_reg <= state_next;
                    // The final round index is kept so round_o shows where the run ended.
                    if (last_round) begin
                        done_reg <= 1'b1;
                        fsm_reg  <= DONE;
                    end else begin
                        round_reg <= round_reg + ROUND_STEP;
                    end
                end
                DONE: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    fsm_reg  <= IDLE;
                end
                default: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    fsm_reg  <= IDLE;
                end
            endcase
        end
    end

    assign state_o = state_reg;
    assign round_o = round_reg;
    assign busy_o  = busy_reg;
    assign done_o  = done_reg;

endmodule

// File: tb/tb_permutation_iterator.sv
// Self-checking bench for permutation_iterator: directed and random permutations
// compared against an S-box-table reference of the Ascon permutation.
module tb_permutation_iterator;

    logic         clock_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         start_i = 1'b0;
    logic         rounds_sel_i = 1'b0;
    logic [319:0] state_i = '0;
    logic [319:0] state_o;
    logic [3:0]   round_o;
    logic         busy_o;
    logic         done_o;

    int checks = 0;
    int errors = 0;

`ifdef PERM_UNROLL2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    permutation_iterator dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .rounds_sel_i (rounds_sel_i),
        .state_i      (state_i),
        .state_o      (state_o),
        .round_o      (round_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ascon 5-bit S-box, input/output bit 4 corresponds to word x0.
    function automatic logic [4:0] sbox(input logic [4:0] v);
        case (v)
            5'd0:  return 5'h04;  5'd1:  return 5'h0b;  5'd2:  return 5'h1f;  5'd3:  return 5'h14;
            5'd4:  return 5'h1a;  5'd5:  return 5'h15;  5'd6:  return 5'h09;  5'd7:  return 5'h02;
            5'd8:  return 5'h1b;  5'd9:  return 5'h05;  5'd10: return 5'h08;  5'd11: return 5'h12;
            5'd12: return 5'h1d;  5'd13: return 5'h03;  5'd14: return 5'h06;  5'd15: return 5'h1c;
            5'd16: return 5'h1e;  5'd17: return 5'h13;  5'd18: return 5'h07;  5'd19: return 5'h0e;
            5'd20: return 5'h00;  5'd21: return 5'h0d;  5'd22: return 5'h11;  5'd23: return 5'h18;
            5'd24: return 5'h10;  5'd25: return 5'h0c;  5'd26: return 5'h01;  5'd27: return 5'h19;
            5'd28: return 5'h16;  5'd29: return 5'h0a;  5'd30: return 5'h0f;  default: return 5'h17;
        endcase
    endfunction

    function automatic logic [63:0] rot(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int first);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col;
        logic [4:0]  outc;
        logic [3:0]  r4;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        for (int r = first; r <= 11; r++) begin
            r4 = 4'(r);
            x[2] = x[2] ^ {56'd0, ~r4, r4};
            for (int b = 0; b < 64; b++) begin
                col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                outc = sbox(col);
                for (int k = 0; k < 5; k++) y[k][b] = outc[4 - k];
            end
            x[0] = y[0] ^ rot(y[0], 19) ^ rot(y[0], 28);
            x[1] = y[1] ^ rot(y[1], 61) ^ rot(y[1], 39);
            x[2] = y[2] ^ rot(y[2], 1)  ^ rot(y[2], 6);
            x[3] = y[3] ^ rot(y[3], 10) ^ rot(y[3], 17);
            x[4] = y[4] ^ rot(y[4], 7)  ^ rot(y[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Entered at a negedge while the DUT is idle; returns at the negedge of the IDLE
    // cycle after DONE. With hold_start, start_i stays high with junk data throughout.
    task automatic run_op(input logic [319:0] vec, input logic sel, input logic hold_start,
                          output logic [319:0] result, output logic [3:0] last_r);
        int first;
        int n;
        int exp_r;
        int done_cnt;
        logic [319:0] exp_state;
        first = sel ? 6 : 0;
        n = (12 - first) / STEP;
        exp_state = ref_perm(vec, first);
        done_cnt = 0;
        start_i = 1'b1;
        rounds_sel_i = sel;
        state_i = vec;
        @(posedge clock_i);
        #1;
        start_i = hold_start;
        state_i = rand_state();
        rounds_sel_i = ~sel;
        for (int j = 0; j <= n; j++) begin
            @(negedge clock_i);
            exp_r = first + STEP * ((j < n) ? j : n - 1);
            chk($sformatf("round_j%0d_sel%0d", j, sel), {316'd0, round_o}, 320'(exp_r));
            chk($sformatf("busy_j%0d", j), {319'd0, busy_o}, 320'd1);
            if (done_o) done_cnt++;
            if (j == n) chk("done_at_N", {319'd0, done_o}, 320'd1);
            if (hold_start) state_i = rand_state();
        end
        chk("done_count", 320'(done_cnt), 320'd1);
        chk($sformatf("state_sel%0d", sel), state_o, exp_state);
        @(negedge clock_i);
        chk("idle_busy", {319'd0, busy_o}, 320'd0);
        chk("idle_done", {319'd0, done_o}, 320'd0);
        chk("idle_state_hold", state_o, exp_state);
        result = state_o;
        last_r = 4'(first + STEP * (n - 1));
        $display("op sel=%0d hold=%0d rounds=%0d cycles=%0d checks=%0d errors=%0d",
                 sel, hold_start, 12 - first, n, checks, errors);
    endtask

    initial begin
        logic [319:0] golden;
        logic [319:0] res;
        logic [319:0] vec2;
        logic [3:0]   lr;
        int           waited;
        int           done_seen;

        golden = {64'h80400c0600000000, 64'h8a55114d1cb6a9a2, 64'hbe263d4d7aecaaff,
                  64'h4ed0ec0b98c529b7, 64'hc8cddf37bcd0284a};

        repeat (2) @(posedge clock_i);
        @(negedge clock_i);
        chk("rst_state", state_o, 320'd0);
        chk("rst_round", {316'd0, round_o}, 320'd0);
        chk("rst_busy", {319'd0, busy_o}, 320'd0);
        chk("rst_done", {319'd0, done_o}, 320'd0);
        reset_i = 1'b0;
        @(negedge clock_i);

        run_op(golden, 1'b0, 1'b0, res, lr);
        run_op(golden, 1'b1, 1'b0, res, lr);

        // Start held high with changing data: first request wins, next one accepted after DONE.
        run_op(golden, 1'b0, 1'b1, res, lr);
        vec2 = rand_state();
        run_op(vec2, 1'b1, 1'b0, res, lr);

        for (int t = 0; t < 4; t++) begin
            vec2 = rand_state();
            run_op(vec2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), res, lr);
        end
        start_i = 1'b0;

        // Reset during a p^a run once round_o reaches 5.
        start_i = 1'b1;
        rounds_sel_i = 1'b0;
        state_i = golden;
        @(posedge clock_i);
        #1;
        start_i = 1'b0;
        waited = 0;
        @(negedge clock_i);
        while (round_o != 4'd5 && round_o != 4'd6 && waited < 20) begin
            @(negedge clock_i);
            waited++;
        end
        chk("reach_round5_timeout", {319'd0, (waited < 20)}, 320'd1);
        reset_i = 1'b1;
        @(posedge clock_i);
        #1;
        reset_i = 1'b0;
        @(negedge clock_i);
        chk("midrst_state", state_o, 320'd0);
        chk("midrst_round", {316'd0, round_o}, 320'd0);
        chk("midrst_busy", {319'd0, busy_o}, 320'd0);
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock_i);
            if (done_o) done_seen++;
        end
        chk("midrst_no_done", 320'(done_seen), 320'd0);
        $display("reset mid-run: waited=%0d done_seen=%0d", waited, done_seen);

        // Result must stay visible while idle.
        run_op(golden, 1'b0, 1'b0, res, lr);
        for (int c = 0; c < 20; c++) begin
            @(negedge clock_i);
            chk("hold_state", state_o, res);
            chk("hold_round", {316'd0, round_o}, {316'd0, lr});
            chk("hold_busy", {319'd0, busy_o}, 320'd0);
        end
        $display("hold after done: 20 cycles, last round=%0d", lr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
